// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch front end.
package riscv_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, flush invalidates it, otherwise hold.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     flush,
    input  logic [ADDRESS_WIDTH-1:0] cap_pc,
    input  logic [ADDRESS_WIDTH-1:0] cap_pc_plus4,
    input  logic [DATA_WIDTH-1:0]    cap_instr,
    output logic                     if_id_valid,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4,
    output logic [DATA_WIDTH-1:0]    if_id_instr
);

    // Flush wins over load; the PC fields are left as-is since only valid/instr matter downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid    <= 1'b0;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_instr    <= DATA_WIDTH'(NOP);
        end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= DATA_WIDTH'(NOP);
        end else if (load) begin
            if_id_valid    <= 1'b1;
            if_id_pc       <= cap_pc;
            if_id_pc_plus4 <= cap_pc_plus4;
            if_id_instr    <= cap_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, boot/run/halt control and fetch counter.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     halt_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    output logic                     if_id_valid,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc,
    output logic [ADDRESS_WIDTH-1:0] if_id_pc_plus4,
    output logic [DATA_WIDTH-1:0]    if_id_instr,
    output logic                     fetch_misaligned,
    output logic [31:0]              fetch_count,
    output logic                     halted
);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]              count_q, count_d;
    logic                     misaligned_q, misaligned_d;
    logic                     load, flush;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;

    assign pc_plus4    = pc_q + ADDRESS_WIDTH'(4);
    assign redirect_pc = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        misaligned_d = 1'b0;
        load         = 1'b0;
        flush        = 1'b0;

        // A redirect is honoured in RUN and HALTED alike, ahead of halt and stall.
        if (state_q != BOOT && redirect_valid) begin
            pc_d         = redirect_pc;
            flush        = 1'b1;
            misaligned_d = |redirect_target[1:0];
        end

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!redirect_valid) begin
                    if (halt_req) begin
                        state_d = HALTED;
                        flush   = 1'b1;
                    end else if (!stall) begin
                        load    = 1'b1;
                        pc_d    = pc_plus4;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            count_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            misaligned_q <= misaligned_d;
        end
    end

    if_id_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_if_id_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .flush          (flush),
        .cap_pc         (pc_q),
        .cap_pc_plus4   (pc_plus4),
        .cap_instr      (imem_instr),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr)
    );

    assign imem_addr        = pc_q;
    assign fetch_misaligned = misaligned_q;
    assign fetch_count      = count_q;
    assign halted           = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reference model checked every cycle plus directed literal expectations.
module tb_fetch_stage;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        fetch_misaligned;
    logic [31:0] fetch_count;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction ROM: two fixed words at 0 and 4, an address-derived pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return 32'hA500_0000 ^ a;
    endfunction

    assign imem_instr = rom_word(imem_addr);

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .halt_req         (halt_req),
        .imem_addr        (imem_addr),
        .imem_instr       (imem_instr),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_instr      (if_id_instr),
        .fetch_misaligned (fetch_misaligned),
        .fetch_count      (fetch_count),
        .halted           (halted)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = just out of reset, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_count;
    logic        m_valid, m_mis;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_pc    <= 32'h0;
            m_valid <= 1'b0;
            m_ifpc  <= 32'h0;
            m_ifpc4 <= 32'h0;
            m_instr <= NOP_W;
            m_mis   <= 1'b0;
            m_count <= 32'h0;
        end else begin
            m_mis <= 1'b0;
            if (m_mode == 0) begin
                m_mode <= 1;
            end else if (redirect_valid) begin
                m_pc    <= redirect_target & 32'hFFFF_FFFC;
                m_valid <= 1'b0;
                m_instr <= NOP_W;
                m_mis   <= (redirect_target % 4) != 0;
                if (m_mode == 2 && !halt_req) m_mode <= 1;
            end else if (m_mode == 2) begin
                if (!halt_req) m_mode <= 1;
            end else if (halt_req) begin
                m_mode  <= 2;
                m_valid <= 1'b0;
                m_instr <= NOP_W;
            end else if (!stall) begin
                m_ifpc  <= m_pc;
                m_ifpc4 <= m_pc + 32'd4;
                m_instr <= rom_word(m_pc);
                m_valid <= 1'b1;
                m_pc    <= m_pc + 32'd4;
                m_count <= m_count + 32'd1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("model imem_addr", 64'(imem_addr), 64'(m_pc));
        check("model if_id_valid", 64'(if_id_valid), 64'(m_valid));
        check("model if_id_pc", 64'(if_id_pc), 64'(m_ifpc));
        check("model if_id_pc_plus4", 64'(if_id_pc_plus4), 64'(m_ifpc4));
        check("model if_id_instr", 64'(if_id_instr), 64'(m_instr));
        check("model fetch_misaligned", 64'(fetch_misaligned), 64'(m_mis));
        check("model fetch_count", 64'(fetch_count), 64'(m_count));
        check("model halted", 64'(halted), 64'(m_mode == 2));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " valid"}, 64'(if_id_valid), 64'd0);
        check({tag, " if_id_pc"}, 64'(if_id_pc), 64'd0);
        check({tag, " if_id_pc_plus4"}, 64'(if_id_pc_plus4), 64'd0);
        check({tag, " instr"}, 64'(if_id_instr), 64'(NOP_W));
        check({tag, " misaligned"}, 64'(fetch_misaligned), 64'd0);
        check({tag, " count"}, 64'(fetch_count), 64'd0);
        check({tag, " halted"}, 64'(halted), 64'd0);
        check({tag, " imem_addr"}, 64'(imem_addr), 64'd0);
    endtask

    initial begin
        repeat (3) cyc();
        check_reset_values("reset");

        // Boot then two fetches from the ROM.
        rst_n = 1'b1;
        cyc();
        check("boot valid", 64'(if_id_valid), 64'd0);
        cyc();
        check("edge2 pc", 64'(if_id_pc), 64'h0);
        check("edge2 instr", 64'(if_id_instr), 64'h0050_0093);
        check("edge2 valid", 64'(if_id_valid), 64'd1);
        cyc();
        check("edge3 pc", 64'(if_id_pc), 64'h4);
        check("edge3 instr", 64'(if_id_instr), 64'h0010_0113);
        check("edge3 count", 64'(fetch_count), 64'd2);

        // Three stalled cycles at pc=8.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall imem_addr", 64'(imem_addr), 64'h8);
            check("stall if_id_pc", 64'(if_id_pc), 64'h4);
            check("stall count", 64'(fetch_count), 64'd2);
        end
        stall = 1'b0;
        cyc();
        check("resume pc", 64'(if_id_pc), 64'h8);
        check("resume count", 64'(fetch_count), 64'd3);

        // Misaligned redirect while stalled.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0042;
        cyc();
        stall = 1'b0;
        redirect_valid = 1'b0;
        check("redir imem_addr", 64'(imem_addr), 64'h40);
        check("redir valid", 64'(if_id_valid), 64'd0);
        check("redir instr", 64'(if_id_instr), 64'(NOP_W));
        check("redir misaligned", 64'(fetch_misaligned), 64'd1);
        check("redir count", 64'(fetch_count), 64'd3);
        cyc();
        check("misaligned one cycle", 64'(fetch_misaligned), 64'd0);
        check("post redir pc", 64'(if_id_pc), 64'h40);

        // Aligned redirect to 0x10, then halt for four cycles with a redirect inside.
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0010;
        cyc();
        redirect_valid = 1'b0;
        check("aligned redir misaligned", 64'(fetch_misaligned), 64'd0);
        halt_req = 1'b1;
        cyc();
        check("halt halted", 64'(halted), 64'd1);
        check("halt imem_addr", 64'(imem_addr), 64'h10);
        check("halt valid", 64'(if_id_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0080;
        cyc();
        redirect_valid = 1'b0;
        check("halt redir addr", 64'(imem_addr), 64'h80);
        check("halt redir halted", 64'(halted), 64'd1);
        cyc();
        cyc();
        check("halt count", 64'(fetch_count), 64'd4);
        halt_req = 1'b0;
        cyc();
        check("unhalt halted", 64'(halted), 64'd0);
        check("unhalt valid", 64'(if_id_valid), 64'd0);
        cyc();
        check("unhalt first pc", 64'(if_id_pc), 64'h80);
        check("unhalt first valid", 64'(if_id_valid), 64'd1);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("wrap if_id_pc", 64'(if_id_pc), 64'hFFFF_FFFC);
        check("wrap pc_plus4", 64'(if_id_pc_plus4), 64'h0);
        check("wrap imem_addr", 64'(imem_addr), 64'h0);
        cyc();
        check("wrap next pc", 64'(if_id_pc), 64'h0);

        // Asynchronous reset mid-cycle with a redirect and halt pending.
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0200;
        halt_req = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        cyc();
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        rst_n = 1'b1;
        cyc();
        check("rerelease boot valid", 64'(if_id_valid), 64'd0);
        cyc();
        check("rerelease valid", 64'(if_id_valid), 64'd1);
        check("rerelease pc", 64'(if_id_pc), 64'h0);
        check("rerelease instr", 64'(if_id_instr), 64'h0050_0093);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
